letter_code_deser: RTL and testbench

//  Serial-to-parallel front end for the 6-bit letter decoder: receives framed

---
 rtl/letter_code_deser_if.sv | 32 +++
 rtl/letter_code_deser.sv | 141 ++++++++++++++
 tb/tb_letter_code_deser.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/letter_code_deser_if.sv
// letter_code_deser_if
//   Groups the serial line and the decoded-letter outputs of
//   letter_code_deser so the block can be connected as a single bus.
//   master: the side that drives the line (the upstream source or a bench).
//   slave : the deserializer itself.
// Signals
//   serial_in     line data, idle level 1
//   sample_en     bit-period enable; the line is sampled only when 1
//   A..F          last good code (A = first data bit received)
//   code_ready    1-cycle pulse: a new code was loaded on A..F
//   parity_error  1-cycle pulse: frame dropped because of a parity mismatch
//   frame_error   1-cycle pulse: frame dropped because the stop bit was 0
//   busy          1 while a frame is in progress or a break is pending
interface letter_code_deser_if;
  logic serial_in;
  logic sample_en;
  logic A, B, C, D, E, F;
  logic code_ready;
  logic parity_error;
  logic frame_error;
  logic busy;

  modport master (
    output serial_in, sample_en,
    input  A, B, C, D, E, F, code_ready, parity_error, frame_error, busy
  );

  modport slave (
    input  serial_in, sample_en,
    output A, B, C, D, E, F, code_ready, parity_error, frame_error, busy
  );
endinterface

// File: rtl/letter_code_deser.sv
// letter_code_deser
//   Serial-to-parallel front end for the 6-bit letter decoder. It receives
//   frames of the form start(0), A..F, [P], stop(1), one bit per sample_en
//   cycle. It presents only clean codes on A..F, together with a 1-cycle
//   code_ready strobe. A bad frame produces a 1-cycle error pulse, and
//   A..F keep their previous value.
// Parameters
//   PARITY_EN   1: the frame carries a parity bit after F; 0: it does not
//   PARITY_ODD  0: even parity (A^..^F^P == 0); 1: odd parity (== 1)
// Ports
//   clock    single system clock; all state changes on posedge
//   reset_L  asynchronous, active-low reset
//   bus      letter_code_deser_if.slave (line in, code and status out)
module letter_code_deser #(
  parameter bit PARITY_EN  = 1'b1,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic                clock,
  input  logic                reset_L,
  letter_code_deser_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK
  } state_t;

  state_t      state, state_nxt;
  logic [2:0]  cnt, cnt_nxt;
  logic [5:0]  shreg, shreg_nxt;
  logic        par_bit, par_bit_nxt;
  logic [5:0]  code, code_nxt;
  logic        code_ready, code_ready_nxt;
  logic        parity_error, parity_error_nxt;
  logic        frame_error, frame_error_nxt;
  logic        parity_ok;

  // A frame without a parity bit is always considered parity-clean.
  assign parity_ok = !PARITY_EN || ((^{shreg, par_bit}) == PARITY_ODD);

  // Next-state and next-output logic.
  always_comb begin
    // NOTE: every signal gets a default before the case; otherwise a path
    // that does not assign it would infer a latch.
    state_nxt        = state;
    cnt_nxt          = cnt;
    shreg_nxt        = shreg;
    par_bit_nxt      = par_bit;
    code_nxt         = code;
    code_ready_nxt   = 1'b0;
    parity_error_nxt = 1'b0;
    frame_error_nxt  = 1'b0;

    if (bus.sample_en) begin
      unique case (state)
        S_IDLE: begin
          if (!bus.serial_in) begin
            state_nxt = S_DATA;
            cnt_nxt   = 3'd0;
          end
        end
        S_DATA: begin
          // Shift left, so after six bits A (the first bit received)
          // sits in shreg[5].
          shreg_nxt = {shreg[4:0], bus.serial_in};
          cnt_nxt   = cnt + 3'd1;
          if (cnt == 3'd5) begin
            state_nxt = PARITY_EN ? S_PARITY : S_STOP;
          end
        end
        S_PARITY: begin
          par_bit_nxt = bus.serial_in;
          state_nxt   = S_STOP;
        end
        S_STOP: begin
          if (bus.serial_in) begin
            state_nxt = S_IDLE;
            if (parity_ok) begin
              code_nxt       = shreg;
              code_ready_nxt = 1'b1;
            end else begin
              parity_error_nxt = 1'b1;
            end
          end else begin
            // A bad stop bit takes priority over a parity error.
            frame_error_nxt = 1'b1;
            state_nxt       = S_BREAK;
          end
        end
        S_BREAK: begin
          // Wait for the line to return high. A low level here is not a start bit.
          if (bus.serial_in) begin
            state_nxt = S_IDLE;
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // State register. The output code register is reset as well, so that the
  // decoder sees 000000 after reset.
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      state        <= S_IDLE;
      cnt          <= 3'd0;
      shreg        <= 6'd0;
      par_bit      <= 1'b0;
      code         <= 6'd0;
      code_ready   <= 1'b0;
      parity_error <= 1'b0;
      frame_error  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here, so every register samples the
      // values from before the edge, whatever order the lines are in.
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      shreg        <= shreg_nxt;
      par_bit      <= par_bit_nxt;
      code         <= code_nxt;
      code_ready   <= code_ready_nxt;
      parity_error <= parity_error_nxt;
      frame_error  <= frame_error_nxt;
    end
  end

  assign bus.A            = code[5];
  assign bus.B            = code[4];
  assign bus.C            = code[3];
  assign bus.D            = code[2];
  assign bus.E            = code[1];
  assign bus.F            = code[0];
  assign bus.code_ready   = code_ready;
  assign bus.parity_error = parity_error;
  assign bus.frame_error  = frame_error;
  assign bus.busy         = (state != S_IDLE);

endmodule

// File: tb/tb_letter_code_deser.sv
// tb_letter_code_deser
//   Directed bench for letter_code_deser. u1 runs with parity enabled and
//   even parity. u2 runs without a parity bit (8-bit frames). Inputs are
//   driven 1 time unit after each rising edge, and outputs are checked at
//   that same point.
module tb_letter_code_deser;

  logic clock   = 1'b0;
  logic reset_L = 1'b0;
  int   cyc     = 0;
  int   n_cmp   = 0;
  int   n_err   = 0;
  int   t_first = 0;

  letter_code_deser_if b1 ();
  letter_code_deser_if b2 ();

  letter_code_deser #(.PARITY_EN(1'b1), .PARITY_ODD(1'b0)) u1 (
    .clock   (clock),
    .reset_L (reset_L),
    .bus     (b1.slave)
  );

  letter_code_deser #(.PARITY_EN(1'b0), .PARITY_ODD(1'b0)) u2 (
    .clock   (clock),
    .reset_L (reset_L),
    .bus     (b2.slave)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  wire [5:0] code1 = {b1.A, b1.B, b1.C, b1.D, b1.E, b1.F};
  wire [5:0] code2 = {b2.A, b2.B, b2.C, b2.D, b2.E, b2.F};
  // {code_ready, parity_error, frame_error}
  wire [2:0] puls1 = {b1.code_ready, b1.parity_error, b1.frame_error};
  wire [2:0] puls2 = {b2.code_ready, b2.parity_error, b2.frame_error};

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Present one bit for one sample_en cycle on DUT u (0: u1, 1: u2).
  // The task returns 1 time unit after the edge that sampled the bit.
  task automatic smp(input bit u, input logic b);
    if (!u) begin
      b1.serial_in = b;
      b1.sample_en = 1'b1;
    end else begin
      b2.serial_in = b;
      b2.sample_en = 1'b1;
    end
    @(posedge clock);
    #1;
    b1.sample_en = 1'b0;
    b2.sample_en = 1'b0;
  endtask

  task automatic idle_cycle(input logic line);
    b1.sample_en = 1'b0;
    b2.sample_en = 1'b0;
    b1.serial_in = line;
    b2.serial_in = line;
    @(posedge clock);
    #1;
  endtask

  // Send a complete frame. The parity bit is sent only for u1.
  task automatic frame(input bit u, input logic [5:0] d, input logic p, input logic stop);
    smp(u, 1'b0);
    for (int i = 5; i >= 0; i--) smp(u, d[i]);
    if (!u) smp(u, p);
    smp(u, stop);
  endtask

  initial begin
    b1.serial_in = 1'b1;
    b1.sample_en = 1'b0;
    b2.serial_in = 1'b1;
    b2.sample_en = 1'b0;

    // 1: reset asserted in the middle of idle time
    repeat (2) @(posedge clock);
    #1 reset_L = 1'b1;
    repeat (3) idle_cycle(1'b1);
    reset_L = 1'b0;
    #2;
    check("rst_code", {2'b0, code1}, 8'h00);
    check("rst_pulses", {5'b0, puls1}, 8'h00);
    check("rst_busy", {7'b0, b1.busy}, 8'h00);
    check("rst_code_u2", {2'b0, code2}, 8'h00);
    @(negedge clock) reset_L = 1'b1;
    @(posedge clock);
    #1;

    // 2: good even-parity frame 101010, P=1
    smp(1'b0, 1'b0);
    check("busy_after_start", {7'b0, b1.busy}, 8'h01);
    for (int i = 5; i >= 0; i--) smp(1'b0, i[0] ? 1'b1 : 1'b0);
    smp(1'b0, 1'b1);
    smp(1'b0, 1'b1);
    check("good_code", {2'b0, code1}, 8'b00101010);
    check("good_pulses", {5'b0, puls1}, 8'b00000100);
    check("good_busy", {7'b0, b1.busy}, 8'h00);
    idle_cycle(1'b1);
    check("good_pulse_1clk", {5'b0, puls1}, 8'h00);

    // 3: data 000101 with P=1 gives odd overall parity, so a parity error
    frame(1'b0, 6'b000101, 1'b1, 1'b1);
    check("perr_pulses", {5'b0, puls1}, 8'b00000010);
    check("perr_code_hold", {2'b0, code1}, 8'b00101010);
    idle_cycle(1'b1);
    check("perr_pulse_1clk", {5'b0, puls1}, 8'h00);

    // 4: stop bit 0 gives a frame error, then a break with the line held low
    frame(1'b0, 6'b111111, 1'b0, 1'b0);
    check("ferr_pulses", {5'b0, puls1}, 8'b00000001);
    check("ferr_code_hold", {2'b0, code1}, 8'b00101010);
    smp(1'b0, 1'b0);
    check("break_busy_a", {7'b0, b1.busy}, 8'h01);
    check("break_no_pulse", {5'b0, puls1}, 8'h00);
    smp(1'b0, 1'b0);
    check("break_busy_b", {7'b0, b1.busy}, 8'h01);
    smp(1'b0, 1'b1);
    check("break_exit", {7'b0, b1.busy}, 8'h00);
    frame(1'b0, 6'b000000, 1'b0, 1'b1);
    check("zero_code", {2'b0, code1}, 8'h00);
    check("zero_pulses", {5'b0, puls1}, 8'b00000100);
    // Bad stop with bad parity: only the frame error is reported
    frame(1'b0, 6'b000001, 1'b0, 1'b0);
    check("stop_wins", {5'b0, puls1}, 8'b00000001);
    smp(1'b0, 1'b1);

    // 5: back-to-back frames with sample_en held at 1 continuously
    frame(1'b0, 6'b011010, 1'b1, 1'b1);
    t_first = cyc;
    check("b2b_first_code", {2'b0, code1}, 8'b00011010);
    check("b2b_first_rdy", {5'b0, puls1}, 8'b00000100);
    smp(1'b0, 1'b0);
    check("b2b_rdy_drop", {5'b0, puls1}, 8'h00);
    for (int i = 5; i >= 0; i--) smp(1'b0, (6'b101001 >> i) & 6'd1 ? 1'b1 : 1'b0);
    smp(1'b0, 1'b1);
    smp(1'b0, 1'b1);
    check("b2b_second_code", {2'b0, code1}, 8'b00101001);
    check("b2b_second_rdy", {5'b0, puls1}, 8'b00000100);
    check("b2b_spacing", 8'(cyc - t_first), 8'd9);

    // 6: reset asserted after 3 data bits, on u1
    smp(1'b0, 1'b0);
    smp(1'b0, 1'b0);
    smp(1'b0, 1'b0);
    smp(1'b0, 1'b1);
    check("part_busy", {7'b0, b1.busy}, 8'h01);
    reset_L = 1'b0;
    #1;
    check("part_rst_busy", {7'b0, b1.busy}, 8'h00);
    check("part_rst_pulses", {5'b0, puls1}, 8'h00);
    @(negedge clock) reset_L = 1'b1;
    @(posedge clock);
    #1;
    frame(1'b0, 6'b001101, 1'b1, 1'b1);
    check("after_rst_code", {2'b0, code1}, 8'b00001101);
    check("after_rst_rdy", {5'b0, puls1}, 8'b00000100);

    // 6 again on u2 (no parity bit). The line toggles while sample_en=0
    // during the frame, and those toggles must be ignored.
    smp(1'b1, 1'b0);
    smp(1'b1, 1'b1);
    smp(1'b1, 1'b1);
    smp(1'b1, 1'b0);
    check("u2_part_busy", {7'b0, b2.busy}, 8'h01);
    reset_L = 1'b0;
    #1;
    check("u2_rst_busy", {7'b0, b2.busy}, 8'h00);
    @(negedge clock) reset_L = 1'b1;
    @(posedge clock);
    #1;
    smp(1'b1, 1'b0);
    smp(1'b1, 1'b0);
    idle_cycle(1'b1);
    smp(1'b1, 1'b0);
    idle_cycle(1'b0);
    smp(1'b1, 1'b1);
    smp(1'b1, 1'b1);
    idle_cycle(1'b0);
    smp(1'b1, 1'b0);
    smp(1'b1, 1'b1);
    check("u2_pre_stop_busy", {7'b0, b2.busy}, 8'h01);
    smp(1'b1, 1'b1);
    check("u2_code", {2'b0, code2}, 8'b00001101);
    check("u2_pulses", {5'b0, puls2}, 8'b00000100);
    check("u1_untouched", {5'b0, puls1}, 8'h00);
    idle_cycle(1'b1);
    check("u2_pulse_1clk", {5'b0, puls2}, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
